// File: rtl/hc595_frame_shifter.sv
// Serialises a {sel,seg} pattern into two cascaded 74HC595s and pulses the storage latch.
// Latency: frame starts 1 cycle after the start condition; 29*DIV cycles of shift+latch per frame.
// No backpressure: sel/seg are sampled only at frame start, changes mid-frame wait for the next frame.
module hc595_frame_shifter #(
   parameter int DIV            = 2,
   parameter int ALWAYS_REFRESH = 1
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [5:0] sel,
   input  logic [7:0] seg,
   input  logic       en,
   output logic       ds,
   output logic       shcp,
   output logic       stcp,
   output logic       oe,
   output logic       busy
);

   localparam int              DW       = $clog2(DIV + 1);
   localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
   localparam logic [3:0]      LAST_BIT = 4'd13;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LATCH    = 2'd3
   } state_t;

   state_t        state;
   logic [DW-1:0] div_cnt;
   logic [3:0]    bit_cnt;
   logic [13:0]   shreg;        // remaining bits of the frame, bit 0 is on ds
   logic [13:0]   sent_frame;   // last frame started, for change detection
   logic          first_done;   // a complete latch has happened since reset
   logic          pending_first;

   logic [13:0]   in_frame;
   logic          start;
   logic          div_end;

   assign in_frame = {sel, seg};
   assign start    = (ALWAYS_REFRESH != 0) || pending_first || (in_frame != sent_frame);
   assign div_end  = (div_cnt == DIV_LAST);

   // Frame sequencer: shift 14 bits LSB-first on shcp, then one latch pulse on stcp.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= IDLE;
         div_cnt       <= '0;
         bit_cnt       <= 4'd0;
         shreg         <= 14'd0;
         sent_frame    <= 14'd0;
         first_done    <= 1'b0;
         pending_first <= 1'b1;
         ds            <= 1'b0;
         shcp          <= 1'b0;
         stcp          <= 1'b0;
         busy          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               div_cnt <= '0;
               bit_cnt <= 4'd0;
               ds      <= 1'b0;
               shcp    <= 1'b0;
               stcp    <= 1'b0;
               if (start) begin
                  shreg         <= in_frame;
                  sent_frame    <= in_frame;
                  pending_first <= 1'b0;
                  busy          <= 1'b1;
                  ds            <= in_frame[0];
                  state         <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (div_end) begin
                  div_cnt <= '0;
                  shcp    <= 1'b1;
                  state   <= SHIFT_HI;
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            SHIFT_HI: begin
               if (div_end) begin
                  div_cnt <= '0;
                  shcp    <= 1'b0;
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= 4'd0;
                     ds      <= 1'b0;
                     stcp    <= 1'b1;
                     state   <= LATCH;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                     shreg   <= shreg >> 1;
                     ds      <= shreg[1];
                     state   <= SHIFT_LO;
                  end
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            LATCH: begin
               if (div_end) begin
                  div_cnt    <= '0;
                  stcp       <= 1'b0;
                  busy       <= 1'b0;
                  first_done <= 1'b1;
                  state      <= IDLE;
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output enable: blank until the first full latch so stale 595 contents never show.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         oe <= 1'b1;
      end else begin
         oe <= ~(en & first_done);
      end
   end

endmodule

// File: tb/tb_hc595_frame_shifter.sv
// Bench for hc595_frame_shifter: three instances (DIV=2 refresh, DIV=2 change-detect, DIV=1 refresh).
// Stimulus pushes expected frames into per-instance queues; a monitor rebuilds frames from ds/shcp
// and pops/compares on every stcp rise, also checking pulse widths and frame period.
module tb_hc595_frame_shifter;

   localparam int B_BUSY = 0;
   localparam int B_OE   = 1;
   localparam int B_STCP = 2;
   localparam int B_SHCP = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rst_n_v = 3'b000;
   logic [2:0] en_v    = 3'b111;
   logic [5:0] sel_v [3];
   logic [7:0] seg_v [3];
   logic ds0, shcp0, stcp0, oe0, busy0;
   logic ds1, shcp1, stcp1, oe1, busy1;
   logic ds2, shcp2, stcp2, oe2, busy2;
   logic [4:0] obs [3];

   assign obs[0] = {ds0, shcp0, stcp0, oe0, busy0};
   assign obs[1] = {ds1, shcp1, stcp1, oe1, busy1};
   assign obs[2] = {ds2, shcp2, stcp2, oe2, busy2};

   hc595_frame_shifter #(.DIV(2), .ALWAYS_REFRESH(1)) dut (
      .sys_clk(clk), .sys_rst_n(rst_n_v[0]), .sel(sel_v[0]), .seg(seg_v[0]), .en(en_v[0]),
      .ds(ds0), .shcp(shcp0), .stcp(stcp0), .oe(oe0), .busy(busy0));
   hc595_frame_shifter #(.DIV(2), .ALWAYS_REFRESH(0)) dut_cd (
      .sys_clk(clk), .sys_rst_n(rst_n_v[1]), .sel(sel_v[1]), .seg(seg_v[1]), .en(en_v[1]),
      .ds(ds1), .shcp(shcp1), .stcp(stcp1), .oe(oe1), .busy(busy1));
   hc595_frame_shifter #(.DIV(1), .ALWAYS_REFRESH(1)) dut_d1 (
      .sys_clk(clk), .sys_rst_n(rst_n_v[2]), .sel(sel_v[2]), .seg(seg_v[2]), .en(en_v[2]),
      .ds(ds2), .shcp(shcp2), .stcp(stcp2), .oe(oe2), .busy(busy2));

   int vectors     = 0;
   int miscompares = 0;

   // Expected frames per instance
   logic [13:0] q0 [$];
   logic [13:0] q1 [$];
   logic [13:0] q2 [$];

   // Per-instance timing expectations: DIV and frame period (0 = not back-to-back)
   int divs [3] = '{2, 2, 1};
   int per  [3] = '{59, 0, 30};

   // Directed vectors for the refresh instance, expected frame = {sel,seg} worked by hand
   logic [5:0]  vsel [8] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
                             6'b010000, 6'b100000, 6'b111111, 6'b000000};
   logic [7:0]  vseg [8] = '{8'hC0, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'h00, 8'hFF};
   logic [13:0] vfr  [8] = '{14'h01C0, 14'h02A4, 14'h04B0, 14'h0899,
                             14'h1092, 14'h2082, 14'h3F00, 14'h00FF};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int k, input logic [13:0] v);
      case (k)
         0: q0.push_back(v);
         1: q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   task automatic pop_exp(input int k, output bit ok, output logic [13:0] v);
      ok = 1'b0;
      v  = '0;
      case (k)
         0: if (q0.size() != 0) begin v = q0.pop_front(); ok = 1'b1; end
         1: if (q1.size() != 0) begin v = q1.pop_front(); ok = 1'b1; end
         default: if (q2.size() != 0) begin v = q2.pop_front(); ok = 1'b1; end
      endcase
   endtask

   // Wait for obs[k][b] to change to lvl; returns 1 time unit after the clock edge that did it
   task automatic wait_edge(input int k, input int b, input logic lvl, input int maxc, input string name);
      logic prev;
      bit   done;
      prev = obs[k][b];
      done = 1'b0;
      for (int n = 0; n < maxc && !done; n++) begin
         @(posedge clk);
         #1;
         if (obs[k][b] == lvl && prev != lvl) done = 1'b1;
         prev = obs[k][b];
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout %s (ch%0d bit%0d -> %0b)", name, k, b, lvl);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int          nbit    [3];
   int          hi_run  [3];
   int          st_run  [3];
   int          bz_run  [3];
   int          lat_cnt [3] = '{0, 0, 0};
   int          last_lat[3];
   logic [13:0] got     [3];
   logic [4:0]  prv     [3];
   int          cyc = 0;
   logic [4:0]  m_cur;
   bit          m_ok;
   logic [13:0] m_ev;

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n_v[k]) begin
            nbit[k]     = 0;
            hi_run[k]   = 0;
            st_run[k]   = 0;
            bz_run[k]   = 0;
            last_lat[k] = -1;
            got[k]      = '0;
            prv[k]      = obs[k];
         end else begin
            m_cur = obs[k];
            if (m_cur[B_SHCP] && !prv[k][B_SHCP]) begin
               if (nbit[k] < 14) got[k][nbit[k]] = m_cur[4];
               nbit[k]++;
            end
            if (m_cur[B_STCP] && !prv[k][B_STCP]) begin
               pop_exp(k, m_ok, m_ev);
               chk($sformatf("ch%0d frame expected", k), {31'd0, m_ok}, 32'd1);
               if (m_ok) chk($sformatf("ch%0d frame data", k), {18'd0, got[k]}, {18'd0, m_ev});
               chk($sformatf("ch%0d bits per frame", k), nbit[k], 14);
               if (per[k] != 0 && last_lat[k] >= 0)
                  chk($sformatf("ch%0d frame period", k), cyc - last_lat[k], per[k]);
               last_lat[k] = cyc;
               lat_cnt[k]++;
               nbit[k] = 0;
               got[k]  = '0;
            end
            if (m_cur[B_SHCP]) hi_run[k]++;
            else if (prv[k][B_SHCP]) begin
               chk($sformatf("ch%0d shcp high width", k), hi_run[k], divs[k]);
               hi_run[k] = 0;
            end
            if (m_cur[B_STCP]) st_run[k]++;
            else if (prv[k][B_STCP]) begin
               chk($sformatf("ch%0d stcp width", k), st_run[k], divs[k]);
               st_run[k] = 0;
            end
            if (m_cur[B_BUSY]) bz_run[k]++;
            else if (prv[k][B_BUSY]) begin
               chk($sformatf("ch%0d busy width", k), bz_run[k], 29 * divs[k]);
               bz_run[k] = 0;
            end
            prv[k] = m_cur;
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   int   tog;
   logic s_shcp;

   initial begin
      for (int k = 0; k < 3; k++) begin
         sel_v[k] = '0;
         seg_v[k] = '0;
      end

      // Reset held: outputs idle whatever the inputs do
      for (int i = 0; i < 3; i++) begin
         sel_v[0] = 6'(i * 21 + 5);
         seg_v[0] = 8'(i * 85 + 3);
         en_v[0]  = i[0];
         @(negedge clk);
         chk("reset hold ch0", {27'd0, obs[0]}, 32'h02);
      end
      chk("reset hold ch1", {27'd0, obs[1]}, 32'h02);
      chk("reset hold ch2", {27'd0, obs[2]}, 32'h02);

      // Refresh mode, DIV=2: vectors chained frame to frame, oe behaviour around first latch
      en_v[0]  = 1'b1;
      sel_v[0] = vsel[0];
      seg_v[0] = vseg[0];
      push_exp(0, vfr[0]);
      @(negedge clk);
      rst_n_v[0] = 1'b1;
      for (int f = 0; f < 7; f++) begin
         wait_edge(0, B_BUSY, 1'b1, 200, "ch0 frame start");
         sel_v[0] = vsel[f+1];
         seg_v[0] = vseg[f+1];
         push_exp(0, vfr[f+1]);
         if (f == 0) begin
            wait_edge(0, B_STCP, 1'b1, 200, "ch0 first stcp");
            @(negedge clk);
            chk("oe during first latch", {31'd0, obs[0][B_OE]}, 32'd1);
            wait_edge(0, B_STCP, 1'b0, 20, "ch0 first stcp end");
            @(negedge clk);
            chk("oe on latch end cycle", {31'd0, obs[0][B_OE]}, 32'd1);
         end
         if (f == 1) begin
            @(negedge clk);
            chk("oe after first latch", {31'd0, obs[0][B_OE]}, 32'd0);
            en_v[0] = 1'b0;
            @(negedge clk);
            chk("oe blanked by en", {31'd0, obs[0][B_OE]}, 32'd1);
            tog    = 0;
            s_shcp = obs[0][B_SHCP];
            repeat (4) begin
               @(negedge clk);
               if (obs[0][B_SHCP] != s_shcp) tog++;
               s_shcp = obs[0][B_SHCP];
            end
            chk("shcp toggles while blanked", {31'd0, tog != 0}, 32'd1);
            chk("oe stays blanked", {31'd0, obs[0][B_OE]}, 32'd1);
            en_v[0] = 1'b1;
            @(negedge clk);
            chk("oe unblanked by en", {31'd0, obs[0][B_OE]}, 32'd0);
         end
      end

      // Async reset in the middle of bit 7: no latch, restart from bit 0, oe blank until next latch
      wait_edge(0, B_BUSY, 1'b1, 200, "ch0 abort frame start");
      repeat (7) wait_edge(0, B_SHCP, 1'b1, 20, "ch0 shcp rise");
      wait_edge(0, B_SHCP, 1'b0, 20, "ch0 bit7 start");
      #2;
      rst_n_v[0] = 1'b0;
      #1;
      chk("async reset outputs", {27'd0, obs[0]}, 32'h02);
      q0.delete();
      sel_v[0] = 6'b010101;
      seg_v[0] = 8'h5A;
      push_exp(0, 14'h155A);
      repeat (2) @(negedge clk);
      chk("held reset no stcp", {31'd0, obs[0][B_STCP]}, 32'd0);
      rst_n_v[0] = 1'b1;
      wait_edge(0, B_BUSY, 1'b1, 10, "ch0 restart");
      @(negedge clk);
      chk("oe blank after reset", {31'd0, obs[0][B_OE]}, 32'd1);
      wait_edge(0, B_STCP, 1'b1, 200, "ch0 restart stcp");
      @(negedge clk);
      chk("oe blank until latch done", {31'd0, obs[0][B_OE]}, 32'd1);
      wait_edge(0, B_STCP, 1'b0, 20, "ch0 restart stcp end");
      @(negedge clk);
      chk("oe on restart latch end", {31'd0, obs[0][B_OE]}, 32'd1);
      @(negedge clk);
      chk("oe on after restart latch", {31'd0, obs[0][B_OE]}, 32'd0);
      rst_n_v[0] = 1'b0;

      // Change-detect mode: C0 frame, mid-frame change to F9 gives exactly one more frame
      sel_v[1] = 6'b000001;
      seg_v[1] = 8'hC0;
      push_exp(1, 14'h01C0);
      @(negedge clk);
      rst_n_v[1] = 1'b1;
      wait_edge(1, B_BUSY, 1'b1, 10, "ch1 frame start");
      seg_v[1] = 8'hF9;
      push_exp(1, 14'h01F9);
      wait_edge(1, B_STCP, 1'b1, 200, "ch1 stcp 1");
      wait_edge(1, B_STCP, 1'b1, 200, "ch1 stcp 2");
      repeat (200) @(negedge clk);
      chk("ch1 frame count", lat_cnt[1], 2);
      chk("ch1 idle busy", {31'd0, obs[1][B_BUSY]}, 32'd0);
      chk("ch1 queue drained", q1.size(), 0);
      rst_n_v[1] = 1'b0;

      // DIV=1 refresh: three frames, 30-cycle period, 1-cycle shcp/stcp pulses
      sel_v[2] = 6'b100000;
      seg_v[2] = 8'h92;
      repeat (3) push_exp(2, 14'h2092);
      @(negedge clk);
      rst_n_v[2] = 1'b1;
      repeat (3) wait_edge(2, B_STCP, 1'b1, 100, "ch2 stcp");
      @(negedge clk);
      #1;
      rst_n_v[2] = 1'b0;
      chk("ch2 frame count", lat_cnt[2], 3);
      chk("ch2 queue drained", q2.size(), 0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
